// File: rtl/rgb2gray.sv
// rgb2gray: front end of the edge-detection pipeline.
//
// Takes 32-bit RGB beats from an AXI-Stream slave and converts each one to an
// 8-bit luminance value:
//   gray = sat255((R*cr + G*cg + B*cb + 128) >> 8)
// The three weights are 0.8 fixed-point fractions.
//
// Pipeline: S1 registers the three products and S2 registers the saturated sum.
// Both stages advance together on adv = ~gray_valid | gauss_axi_ready.
// A one-entry skid buffer catches a beat that is accepted while the pipeline
// is stalled. This lets s_axis_tready be a plain flop (~skid_full).
//
// Column and row counters follow every accepted beat. gray_last marks the
// last column of a line, and frame_done pulses once the last pixel of a frame
// has been transferred downstream.
//
// Optional feature (macro RGB2GRAY_LAST_CHECK_EN):
//   - s_axis_tlast is checked against the column counter.
//   - A mismatch sets the sticky err_last flag.
//   - An early tlast resynchronises the counters to the start of a new line.
//   When the macro is undefined, tlast is ignored and err_last is tied to 0.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   s_axis_tdata       pixel R=[7:0] G=[15:8] B=[23:16]; [31:24] ignored
//   s_axis_tkeep       byte enables; a cleared bit zeroes that colour byte
//   s_axis_tlast       upstream line-end marker
//   s_axis_tvalid      input beat valid
//   s_axis_tready      input ready (registered)
//   coe_r/g/b_in       luminance weights, 0.xxxx_xxxx
//   gauss_axi_ready    downstream ready
//   gray_out           luminance
//   gray_valid         gray_out valid
//   gray_last          last pixel of a line (qualified by gray_valid)
//   frame_done         one-cycle pulse after the frame's last pixel transfers
//   err_last           sticky tlast-position error
module rgb2gray #(
  parameter int unsigned IMG_W = 1024,
  parameter int unsigned IMG_H = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  coe_r_in,
  input  logic [7:0]  coe_g_in,
  input  logic [7:0]  coe_b_in,
  input  logic        gauss_axi_ready,
  output logic [7:0]  gray_out,
  output logic        gray_valid,
  output logic        gray_last,
  output logic        frame_done,
  output logic        err_last
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);

  // Registered weights
  logic [7:0]      r_coe_r, r_coe_g, r_coe_b;

  // Input side
  logic            r_tready;
  logic            r_skid_full;
  logic [23:0]     r_skid_pix;
  logic            r_skid_last, r_skid_flast;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;

  // S1: products
  logic            r_s1_valid;
  logic [15:0]     r_s1_pr, r_s1_pg, r_s1_pb;
  logic            r_s1_last, r_s1_flast;

  // S2: output
  logic [7:0]      r_gray_out;
  logic            r_gray_valid, r_gray_last, r_gray_flast;
  logic            r_frame_done;

  logic            w_adv, w_acc;
  logic [23:0]     w_in_pix;
  logic            w_col_end, w_row_end, w_resync, w_wrap;
  logic            w_in_last, w_in_flast;
  logic [ColW-1:0] w_col_d;
  logic [RowW-1:0] w_row_d;
  logic            w_skid_full_d;
  logic            w_s1_in_valid;
  logic [23:0]     w_s1_pix;
  logic            w_s1_last, w_s1_flast;
  logic [17:0]     w_sum;
  logic [9:0]      w_shift;
  logic [7:0]      w_gray_sat;
  logic            w_unused;

  assign w_adv = ~r_gray_valid | gauss_axi_ready;
  assign w_acc = s_axis_tvalid & r_tready;

  assign w_in_pix = {s_axis_tkeep[2] ? s_axis_tdata[23:16] : 8'h00,
                     s_axis_tkeep[1] ? s_axis_tdata[15:8]  : 8'h00,
                     s_axis_tkeep[0] ? s_axis_tdata[7:0]   : 8'h00};

  assign w_col_end = (r_col == ColMax);
  assign w_row_end = (r_row == RowMax);

`ifdef RGB2GRAY_LAST_CHECK_EN
  // An early tlast closes the line: the next beat starts column 0 of a new row.
  assign w_resync = s_axis_tlast & ~w_col_end;
`else
  assign w_resync = 1'b0;
`endif

  assign w_wrap     = w_col_end | w_resync;
  assign w_in_last  = w_col_end;
  assign w_in_flast = w_col_end & w_row_end;
  assign w_col_d    = w_wrap ? '0 : r_col + 1'b1;
  assign w_row_d    = !w_wrap ? r_row : (w_row_end ? '0 : r_row + 1'b1);

  // The skid fills only when a beat arrives during a stall. It empties on the
  // next advance. While it is full, tready is low, so the two never collide.
  assign w_skid_full_d = w_adv ? 1'b0 : (r_skid_full | w_acc);

  // S1 takes the skid entry first so that pixel order is preserved.
  assign w_s1_in_valid = r_skid_full | w_acc;
  assign w_s1_pix      = r_skid_full ? r_skid_pix   : w_in_pix;
  assign w_s1_last     = r_skid_full ? r_skid_last  : w_in_last;
  assign w_s1_flast    = r_skid_full ? r_skid_flast : w_in_flast;

  assign w_sum      = 18'(r_s1_pr) + 18'(r_s1_pg) + 18'(r_s1_pb) + 18'd128;
  assign w_shift    = w_sum[17:8];
  assign w_gray_sat = (|w_shift[9:8]) ? 8'hFF : w_shift[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coe_r      <= '0;
      r_coe_g      <= '0;
      r_coe_b      <= '0;
      r_tready     <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_pix   <= '0;
      r_skid_last  <= 1'b0;
      r_skid_flast <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_pr      <= '0;
      r_s1_pg      <= '0;
      r_s1_pb      <= '0;
      r_s1_last    <= 1'b0;
      r_s1_flast   <= 1'b0;
      r_gray_out   <= '0;
      r_gray_valid <= 1'b0;
      r_gray_last  <= 1'b0;
      r_gray_flast <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_coe_r     <= coe_r_in;
      r_coe_g     <= coe_g_in;
      r_coe_b     <= coe_b_in;
      r_tready    <= ~w_skid_full_d;
      r_skid_full <= w_skid_full_d;

      if (w_acc && !w_adv) begin
        r_skid_pix   <= w_in_pix;
        r_skid_last  <= w_in_last;
        r_skid_flast <= w_in_flast;
      end

      if (w_acc) begin
        r_col <= w_col_d;
        r_row <= w_row_d;
      end

      if (w_adv) begin
        r_s1_valid   <= w_s1_in_valid;
        r_s1_pr      <= 16'(w_s1_pix[7:0])   * 16'(r_coe_r);
        r_s1_pg      <= 16'(w_s1_pix[15:8])  * 16'(r_coe_g);
        r_s1_pb      <= 16'(w_s1_pix[23:16]) * 16'(r_coe_b);
        r_s1_last    <= w_s1_in_valid & w_s1_last;
        r_s1_flast   <= w_s1_in_valid & w_s1_flast;
        r_gray_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_gray_out <= w_gray_sat;
        end
        r_gray_last  <= r_s1_valid & r_s1_last;
        r_gray_flast <= r_s1_valid & r_s1_flast;
      end

      r_frame_done <= r_gray_valid & gauss_axi_ready & r_gray_flast;
    end
  end

`ifdef RGB2GRAY_LAST_CHECK_EN
  logic r_err_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_last <= 1'b0;
    end else if (w_acc && (s_axis_tlast != w_col_end)) begin
      r_err_last <= 1'b1;
    end
  end

  assign err_last = r_err_last;
`else
  assign err_last = 1'b0;
`endif

  assign s_axis_tready = r_tready;
  assign gray_out      = r_gray_out;
  assign gray_valid    = r_gray_valid;
  assign gray_last     = r_gray_last;
  assign frame_done    = r_frame_done;

  // Alpha byte and its keep bit never reach the datapath.
  assign w_unused = ^{s_axis_tdata[31:24], s_axis_tkeep[3], s_axis_tlast};

endmodule

// File: tb/tb_rgb2gray.sv
// Self-checking bench for rgb2gray with a small 8x4 frame.
// Expected pixels go into a scoreboard queue when a beat is accepted and are
// popped when the DUT transfers an output.
module tb_rgb2gray;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
`ifdef RGB2GRAY_LAST_CHECK_EN
  localparam bit LastCheck = 1'b1;
`else
  localparam bit LastCheck = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  coe_r_in, coe_g_in, coe_b_in;
  logic        gauss_axi_ready;
  logic [7:0]  gray_out;
  logic        gray_valid, gray_last, frame_done, err_last;

  always #5 clk = ~clk;

  rgb2gray #(.IMG_W(W), .IMG_H(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .coe_r_in        (coe_r_in),
    .coe_g_in        (coe_g_in),
    .coe_b_in        (coe_b_in),
    .gauss_axi_ready (gauss_axi_ready),
    .gray_out        (gray_out),
    .gray_valid      (gray_valid),
    .gray_last       (gray_last),
    .frame_done      (frame_done),
    .err_last        (err_last)
  );

  typedef struct packed {
    logic [7:0] gray;
    logic       last;
    logic       flast;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [31:0] d, input logic [3:0] k);
    int r, g, b, s;
    r = k[0] ? int'(d[7:0])   : 0;
    g = k[1] ? int'(d[15:8])  : 0;
    b = k[2] ? int'(d[23:16]) : 0;
    s = (r * int'(coe_r_in) + g * int'(coe_g_in) + b * int'(coe_b_in) + 128) / 256;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Reference state, updated on the falling edge
  int         m_col, m_row;
  bit         m_skid, m_err, exp_tready, exp_tready_vld, exp_fd, stall_prev;
  logic [7:0] prev_out;
  logic       prev_last;
  int         n_out, n_fd, n_lastout;
  bit         mon_acc, mon_adv;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_col          = 0;
      m_row          = 0;
      m_skid         = 1'b0;
      m_err          = 1'b0;
      exp_tready     = 1'b0;
      exp_tready_vld = 1'b1;
      exp_fd         = 1'b0;
      stall_prev     = 1'b0;
    end else begin
      if (exp_tready_vld) check_eq("tready", s_axis_tready, exp_tready);
      check_eq("frame_done", frame_done, exp_fd);
      check_eq("err_last", err_last, m_err);
      if (stall_prev) begin
        check_eq("stall_valid", gray_valid, 1);
        check_eq("stall_data", gray_out, prev_out);
        check_eq("stall_last", gray_last, prev_last);
      end
      if (frame_done) n_fd++;

      mon_adv = !gray_valid || gauss_axi_ready;
      exp_fd  = 1'b0;
      if (gray_valid && gauss_axi_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_output", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_gray", gray_out, mon_e.gray);
          check_eq("sb_last", gray_last, mon_e.last);
          exp_fd = mon_e.flast;
          n_out++;
          if (mon_e.last) n_lastout++;
        end
      end

      mon_acc = s_axis_tvalid && s_axis_tready;
      if (mon_acc) begin
        mon_e.gray  = ref_gray(s_axis_tdata, s_axis_tkeep);
        mon_e.last  = (m_col == W - 1);
        mon_e.flast = (m_col == W - 1) && (m_row == H - 1);
        sb_q.push_back(mon_e);
        if (LastCheck && (s_axis_tlast != (m_col == W - 1))) m_err = 1'b1;
        if ((m_col == W - 1) || (LastCheck && s_axis_tlast)) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end

      // One-entry skid: filled by a beat accepted during a stall, drained on advance.
      m_skid     = m_skid ? !mon_adv : (mon_acc && !mon_adv);
      exp_tready = !m_skid;
      stall_prev = gray_valid && !gauss_axi_ready;
      prev_out   = gray_out;
      prev_last  = gray_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int  t;
    bit  ok;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_px(input logic [31:0] d);
    send_beat(d, 4'hF, m_col == W - 1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq(tag, sb_q.size(), 0);
    idle(3);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single beat into an empty pipeline with ready held high; it checks latency and value.
  task automatic direct(input logic [31:0] d, input logic [3:0] k, input logic [7:0] exp,
                        input string tag);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = (m_col == W - 1);
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ready"}, s_axis_tready, 1);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat1_valid"}, gray_valid, 0);
    @(negedge clk);
    check_eq({tag, "_lat2_valid"}, gray_valid, 1);
    check_eq(tag, gray_out, exp);
    idle(2);
  endtask

  task automatic set_coe(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    coe_r_in = r;
    coe_g_in = g;
    coe_b_in = b;
    idle(2);
  endtask

  int  base_out, base_fd, base_last;
  bit  rnd_done;

  initial begin
    rst_n           = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tkeep    = 4'hF;
    s_axis_tlast    = 1'b0;
    s_axis_tvalid   = 1'b0;
    gauss_axi_ready = 1'b1;
    coe_r_in        = 8'd77;
    coe_g_in        = 8'd150;
    coe_b_in        = 8'd29;
    n_out           = 0;
    n_fd            = 0;
    n_lastout       = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_gray_out", gray_out, 0);
    check_eq("rst_gray_valid", gray_valid, 0);
    check_eq("rst_gray_last", gray_last, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_err_last", err_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed conversions
    direct(32'h00FF_FFFF, 4'hF, 8'd255, "white_77_150_29");
    direct(32'h0000_0064, 4'hF, 8'd30,  "red100");
    direct(32'hFF00_0064, 4'hF, 8'd30,  "alpha_ignored");
    direct(32'h00FF_FFFF, 4'hE, 8'd178, "keep_no_red");
    set_coe(8'd255, 8'd255, 8'd255);
    direct(32'h00FF_FFFF, 4'hF, 8'd255, "saturate");
    direct(32'h0001_0101, 4'hF, 8'd3,   "ones_255");
    set_coe(8'd77, 8'd150, 8'd29);

    // Full 8x4 frame from (0,0)
    reset_dut();
    idle(2);
    base_out  = n_out;
    base_fd   = n_fd;
    base_last = n_lastout;
    for (int i = 0; i < int'(W * H); i++) send_px({8'h00, 8'(i * 5), 8'(i * 3), 8'(i * 7)});
    drain("frame_drain");
    check_eq("frame_outputs", n_out - base_out, W * H);
    check_eq("frame_lasts", n_lastout - base_last, H);
    check_eq("frame_done_count", n_fd - base_fd, 1);

    // 100 incrementing pixels against a randomly stalling consumer
    base_out = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          send_px({8'hA5, 8'(i + 2), 8'(i + 1), 8'(i)});
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 gauss_axi_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    gauss_axi_ready = 1'b1;
    drain("random_drain");
    check_eq("random_outputs", n_out - base_out, 100);

    // Reset with two pixels in flight
    reset_dut();
    idle(1);
    send_px(32'h0012_3456);
    send_px(32'h0065_4321);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", gray_valid, 0);
    check_eq("midrst_tready", s_axis_tready, 0);
    base_out  = n_out;
    base_last = n_lastout;
    for (int i = 0; i < int'(W); i++) send_px({8'h00, 8'(i), 8'(40 + i), 8'(200 - i)});
    drain("midrst_drain");
    check_eq("midrst_outputs", n_out - base_out, W);
    check_eq("midrst_lasts", n_lastout - base_last, 1);

    // tlast asserted early at column 5
    reset_dut();
    idle(1);
    for (int i = 0; i < 5; i++) send_px({8'h00, 8'(i), 8'(i), 8'(i)});
    send_beat(32'h0033_3333, 4'hF, 1'b1);
    for (int i = 0; i < int'(W); i++) send_px({8'h00, 8'(9 * i), 8'(i), 8'(3 * i)});
    drain("tlast_drain");
    check_eq("err_last_sticky", err_last, LastCheck);

    check_eq("sb_empty_end", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
